wb_rr_arbiter: RTL

Round-robin arbiter that shares one pipelined Wishbone B4 slave port between g_num_masters pipelined masters. It sits between testbench or RTL masters (e.g. several BFM-driven ports) and a single interconnect or slave. It grants whole cycles (CYC-to-CYC) and tracks outstanding transfers so responses always route to the owning master. Addressing is byte-granular and is passed through unmodified.

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_rr_arb_select.sv | 15 +
 rtl/wb_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type, master limit and round-robin pick for the Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic {IDLE, OWNED} t_wb_arb_state;
  localparam int c_wb_arb_max_masters = 8;
  // Zero-padded request bits above N never win, so a mod-8 walk equals a mod-N walk
  function automatic logic [2:0] f_rr_pick(input logic [c_wb_arb_max_masters-1:0] req, input logic [2:0] last);
    f_rr_pick = last;
    for (int i = c_wb_arb_max_masters; i >= 1; i--) begin
      if (req[last + 3'(i)]) f_rr_pick = last + 3'(i);
    end
  endfunction
endpackage

// File: rtl/wb_rr_arb_select.sv
// wb_rr_arb_select: combinational round-robin winner search starting after the last grant
module wb_rr_arb_select
  import wb_arb_pkg::*;
#(
  parameter int g_num_masters = 2,
  localparam int c_iw = $clog2(g_num_masters)
) (
  input  logic [g_num_masters-1:0] req,
  input  logic [c_iw-1:0]          last,
  output logic                     valid,
  output logic [c_iw-1:0]          idx
);
  assign valid = |req;
  assign idx = c_iw'(f_rr_pick(c_wb_arb_max_masters'(req), 3'(last)));
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin sharing of one pipelined Wishbone B4 slave between N masters
// Optional watchdog abort enabled by WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int g_num_masters     = 2,
  parameter int g_addr_width      = 32,
  parameter int g_data_width      = 32,
  parameter int g_max_outstanding = 4,
  parameter int g_timeout         = 256
) (
  input  logic                                      clk_i,
  input  logic                                      rst_n_i,
  input  logic [g_num_masters-1:0]                  m_cyc_i,
  input  logic [g_num_masters-1:0]                  m_stb_i,
  input  logic [g_num_masters-1:0]                  m_we_i,
  input  logic [g_num_masters*(g_data_width/8)-1:0] m_sel_i,
  input  logic [g_num_masters*g_addr_width-1:0]     m_adr_i,
  input  logic [g_num_masters*g_data_width-1:0]     m_dat_i,
  output logic [g_num_masters-1:0]                  m_ack_o,
  output logic [g_num_masters-1:0]                  m_err_o,
  output logic [g_num_masters-1:0]                  m_rty_o,
  output logic [g_num_masters-1:0]                  m_stall_o,
  output logic [g_data_width-1:0]                   m_dat_o,
  output logic                                      s_cyc_o,
  output logic                                      s_stb_o,
  output logic                                      s_we_o,
  output logic [g_data_width/8-1:0]                 s_sel_o,
  output logic [g_addr_width-1:0]                   s_adr_o,
  output logic [g_data_width-1:0]                   s_dat_o,
  input  logic                                      s_ack_i,
  input  logic                                      s_err_i,
  input  logic                                      s_rty_i,
  input  logic                                      s_stall_i,
  input  logic [g_data_width-1:0]                   s_dat_i,
  output logic [g_num_masters-1:0]                  grant_o,
  output logic                                      busy_o
);
  localparam int c_sw = g_data_width / 8;
  localparam int c_iw = $clog2(g_num_masters);

  if (g_num_masters < 2 || g_num_masters > c_wb_arb_max_masters || g_max_outstanding < 1 ||
      g_max_outstanding > 15 || g_timeout < 1) begin : g_bad_params
    $error("wb_rr_arbiter: parameter out of range");
  end

  t_wb_arb_state            state;
  logic [g_num_masters-1:0] grant;
  logic [c_iw-1:0]          owner, last, pick;
  logic [3:0]               cnt;
  logic                     pick_valid, owned, own_cyc, full, acc, rsp, dec, fire;

  wb_rr_arb_select #(.g_num_masters(g_num_masters)) u_select (
    .req   (m_cyc_i),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick)
  );

  assign owned   = state == OWNED;
  assign own_cyc = owned & m_cyc_i[owner] & ~fire;
  assign full    = cnt == 4'(g_max_outstanding);
  assign rsp     = s_ack_i | s_err_i | s_rty_i;
  assign acc     = s_stb_o & ~s_stall_i;
  assign dec     = rsp & (cnt != '0);

  assign s_cyc_o = own_cyc;
  assign s_stb_o = own_cyc & m_stb_i[owner] & ~full;
  assign s_we_o  = m_we_i[owner];
  assign s_sel_o = m_sel_i[owner*c_sw +: c_sw];
  assign s_adr_o = m_adr_i[owner*g_addr_width +: g_addr_width];
  assign s_dat_o = m_dat_i[owner*g_data_width +: g_data_width];

  // grant is zero outside OWNED, so idle and non-owner masters see stall and no responses
  assign m_stall_o = ~grant | {g_num_masters{s_stall_i | full}};
  assign m_ack_o   = grant & {g_num_masters{s_ack_i}};
  assign m_err_o   = grant & {g_num_masters{s_err_i | fire}};
  assign m_rty_o   = grant & {g_num_masters{s_rty_i}};
  assign m_dat_o   = s_dat_i;
  assign grant_o   = grant;
  assign busy_o    = owned;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      last  <= c_iw'(g_num_masters - 1);
      cnt   <= '0;
    end else if (!owned) begin
      cnt <= '0;
      if (pick_valid) begin
        state <= OWNED;
        grant <= g_num_masters'(1) << pick;
        owner <= pick;
        last  <= pick;
      end
    end else if (!m_cyc_i[owner] || fire) begin
      state <= IDLE;
      grant <= '0;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 4'(acc) - 4'(dec);
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int c_ww = $clog2(g_timeout) + 1;
  logic [c_ww-1:0] wd;
  // Counts idle cycles since the last accept or response while transfers are pending
  assign fire = owned && cnt != '0 && wd == c_ww'(g_timeout - 1);
  always_ff @(posedge clk_i)
    wd <= (!rst_n_i || !owned || cnt == '0 || rsp || acc || fire) ? '0 : wd + c_ww'(1);
`else
  assign fire = 1'b0;
`endif

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_i) !(owned && rsp && cnt == '0))
    else $error("wb_rr_arbiter: response with no outstanding transfer");
endmodule
